// File: rtl/axil_master_cmd.sv
// Single-outstanding AXI4-Lite initiator: one user command becomes one AXI4-Lite
// write or read, and the outcome is returned on a held valid/ready response port.
module axil_master_cmd #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_was_write,
    output logic                            busy,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_RSP
    } state_t;

    state_t          state_reg, state_next;

    logic [AW-1:0]   awaddr_reg, awaddr_next;
    logic [DW-1:0]   wdata_reg, wdata_next;
    logic [SW-1:0]   wstrb_reg, wstrb_next;
    logic [AW-1:0]   araddr_reg, araddr_next;
    logic            awvalid_reg, awvalid_next;
    logic            wvalid_reg, wvalid_next;
    logic            bready_reg, bready_next;
    logic            arvalid_reg, arvalid_next;
    logic            rready_reg, rready_next;

    logic            rsp_valid_reg, rsp_valid_next;
    logic [DW-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic [1:0]      rsp_resp_reg, rsp_resp_next;
    logic            rsp_was_write_reg, rsp_was_write_next;

    logic            aw_pending;
    logic            w_pending;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_reg         <= ST_IDLE;
            awaddr_reg        <= '0;
            wdata_reg         <= '0;
            wstrb_reg         <= '0;
            araddr_reg        <= '0;
            awvalid_reg       <= 1'b0;
            wvalid_reg        <= 1'b0;
            bready_reg        <= 1'b0;
            arvalid_reg       <= 1'b0;
            rready_reg        <= 1'b0;
            rsp_valid_reg     <= 1'b0;
            rsp_rdata_reg     <= '0;
            rsp_resp_reg      <= 2'b00;
            rsp_was_write_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            awaddr_reg        <= awaddr_next;
            wdata_reg         <= wdata_next;
            wstrb_reg         <= wstrb_next;
            araddr_reg        <= araddr_next;
            awvalid_reg       <= awvalid_next;
            wvalid_reg        <= wvalid_next;
            bready_reg        <= bready_next;
            arvalid_reg       <= arvalid_next;
            rready_reg        <= rready_next;
            rsp_valid_reg     <= rsp_valid_next;
            rsp_rdata_reg     <= rsp_rdata_next;
            rsp_resp_reg      <= rsp_resp_next;
            rsp_was_write_reg <= rsp_was_write_next;
        end
    end

    // Every AXI output is a flop; this block only computes what those flops load next.
    always_comb begin
        state_next         = state_reg;
        awaddr_next        = awaddr_reg;
        wdata_next         = wdata_reg;
        wstrb_next         = wstrb_reg;
        araddr_next        = araddr_reg;
        awvalid_next       = awvalid_reg;
        wvalid_next        = wvalid_reg;
        bready_next        = bready_reg;
        arvalid_next       = arvalid_reg;
        rready_next        = rready_reg;
        rsp_valid_next     = rsp_valid_reg;
        rsp_rdata_next     = rsp_rdata_reg;
        rsp_resp_next      = rsp_resp_reg;
        rsp_was_write_next = rsp_was_write_reg;
        aw_pending         = awvalid_reg & ~M_AXI_AWREADY;
        w_pending          = wvalid_reg & ~M_AXI_WREADY;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        awaddr_next  = cmd_addr;
                        wdata_next   = cmd_wdata;
                        wstrb_next   = cmd_wstrb;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        state_next   = ST_WR_REQ;
                    end else begin
                        araddr_next  = cmd_addr;
                        arvalid_next = 1'b1;
                        state_next   = ST_RD_REQ;
                    end
                end
            end

            ST_WR_REQ: begin
                // AW and W retire independently; a finished channel just stays low.
                awvalid_next = aw_pending;
                wvalid_next  = w_pending;
                if (!aw_pending && !w_pending) begin
                    bready_next = 1'b1;
                    state_next  = ST_WR_RESP;
                end
            end

            ST_WR_RESP: begin
                if (bready_reg && M_AXI_BVALID) begin
                    bready_next        = 1'b0;
                    rsp_resp_next      = M_AXI_BRESP;
                    rsp_rdata_next     = '0;
                    rsp_was_write_next = 1'b1;
                    rsp_valid_next     = 1'b1;
                    state_next         = ST_RSP;
                end
            end

            ST_RD_REQ: begin
                if (arvalid_reg && M_AXI_ARREADY) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                if (rready_reg && M_AXI_RVALID) begin
                    rready_next        = 1'b0;
                    rsp_rdata_next     = M_AXI_RDATA;
                    rsp_resp_next      = M_AXI_RRESP;
                    rsp_was_write_next = 1'b0;
                    rsp_valid_next     = 1'b1;
                    state_next         = ST_RSP;
                end
            end

            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready     = (state_reg == ST_IDLE);
    assign busy          = (state_reg != ST_IDLE);

    assign rsp_valid     = rsp_valid_reg;
    assign rsp_rdata     = rsp_rdata_reg;
    assign rsp_resp      = rsp_resp_reg;
    assign rsp_was_write = rsp_was_write_reg;

    assign M_AXI_AWADDR  = awaddr_reg;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_reg;
    assign M_AXI_WDATA   = wdata_reg;
    assign M_AXI_WSTRB   = wstrb_reg;
    assign M_AXI_WVALID  = wvalid_reg;
    assign M_AXI_BREADY  = bready_reg;
    assign M_AXI_ARADDR  = araddr_reg;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_reg;
    assign M_AXI_RREADY  = rready_reg;

endmodule

// File: tb/tb_axil_master_cmd.sv
// Bench for axil_master_cmd: a delay-configurable AXI4-Lite slave with a small memory,
// directed scenarios, then randomized commands checked against a word-array model.
module tb_axil_master_cmd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_was_write;
    logic        busy;

    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY = 1'b0;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY = 1'b0;
    logic [1:0]  M_AXI_BRESP = 2'b00;
    logic        M_AXI_BVALID = 1'b0;
    logic        M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY = 1'b0;
    logic [31:0] M_AXI_RDATA = '0;
    logic [1:0]  M_AXI_RRESP = 2'b00;
    logic        M_AXI_RVALID = 1'b0;
    logic        M_AXI_RREADY;

    axil_master_cmd #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_was_write(rsp_was_write), .busy(busy),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Slave configuration (set by the stimulus) and slave-private state.
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit          got_aw = 0, got_w = 0, got_ar = 0, b_fired = 0, r_fired = 0;
    logic [31:0] aw_addr_l = '0, w_data_l = '0, ar_addr_l = '0;
    logic [3:0]  w_strb_l = '0;
    logic [31:0] slv_mem [16];

    // Observations gathered once per cycle.
    int          aw_first, w_first, bready_first;
    int          awv_cycles, wv_cycles, arv_cycles, rrdy_cycles;
    int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    bit          awaddr_moved, bready_early, overlap, ready_while_busy;
    logic        prev_awv = 1'b0;
    logic [31:0] prev_awaddr = '0;
    logic [34:0] rsp_q [$];

    // Reference: what the peripheral's word memory holds after the writes so far.
    logic [31:0] model_mem [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        aw_first = -1; w_first = -1; bready_first = -1;
        awv_cycles = 0; wv_cycles = 0; arv_cycles = 0; rrdy_cycles = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        awaddr_moved = 0; bready_early = 0; overlap = 0; ready_while_busy = 0;
        rsp_q.delete();
    endtask

    task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
        aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int k = 0; k < 4; k++)
            if (s[k]) model_mem[a[5:2]][8*k +: 8] = d[8*k +: 8];
    endtask

    task automatic wait_accept(output int c0);
        c0 = -1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready === 1'b1) begin
                c0 = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        chk("cmd_accepted", c0 >= 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int c0);
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        wait_accept(c0);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input int hold, input logic exp_ww,
                           input logic [1:0] exp_rr, input logic [31:0] exp_rd, output int c_rsp);
        c_rsp = -1;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid === 1'b1) begin
                c_rsp = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        chk({tag, "_rsp_seen"}, c_rsp >= 0, 1);
        if (c_rsp >= 0) begin
            chk({tag, "_was_write"}, rsp_was_write, exp_ww);
            chk({tag, "_resp"}, rsp_resp, exp_rr);
            chk({tag, "_rdata"}, rsp_rdata, exp_rd);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk({tag, "_hold_valid"}, rsp_valid, 1);
                chk({tag, "_hold_resp"}, rsp_resp, exp_rr);
                chk({tag, "_hold_rdata"}, rsp_rdata, exp_rd);
                chk({tag, "_hold_cmd_ready"}, cmd_ready, 0);
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            chk({tag, "_idle_busy"}, busy, 0);
            chk({tag, "_idle_rsp_valid"}, rsp_valid, 0);
        end
    endtask

    // Slave + monitor: decides READY/VALID at each falling edge for the next rising edge,
    // so every handshake is known at the moment it is granted.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                got_aw = 0; got_w = 0; got_ar = 0; b_fired = 0; r_fired = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
                M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
                prev_awv = 0;
            end else begin
                if (M_AXI_AWVALID) begin
                    awv_cycles++;
                    if (aw_first < 0) aw_first = cyc;
                    if (prev_awv && M_AXI_AWADDR !== prev_awaddr) awaddr_moved = 1;
                end
                prev_awv = M_AXI_AWVALID;
                prev_awaddr = M_AXI_AWADDR;
                if (M_AXI_WVALID) begin
                    wv_cycles++;
                    if (w_first < 0) w_first = cyc;
                end
                if (M_AXI_ARVALID) arv_cycles++;
                if (M_AXI_RREADY) rrdy_cycles++;
                if (M_AXI_BREADY) begin
                    if (bready_first < 0) bready_first = cyc;
                    if (aw_hs == 0) bready_early = 1;
                end
                if (M_AXI_ARVALID && (M_AXI_AWVALID || M_AXI_WVALID)) overlap = 1;
                if (cmd_ready && busy) ready_while_busy = 1;
                if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_was_write, rsp_resp, rsp_rdata});

                if (b_fired) begin M_AXI_BVALID = 0; b_fired = 0; end
                if (r_fired) begin M_AXI_RVALID = 0; r_fired = 0; end

                if (!M_AXI_BVALID && got_aw && got_w) begin
                    if (b_cnt >= b_delay) begin
                        M_AXI_BVALID = 1; M_AXI_BRESP = bresp_cfg;
                        b_cnt = 0; got_aw = 0; got_w = 0;
                        for (int k = 0; k < 4; k++)
                            if (w_strb_l[k]) slv_mem[aw_addr_l[5:2]][8*k +: 8] = w_data_l[8*k +: 8];
                    end else b_cnt++;
                end
                if (M_AXI_BVALID && M_AXI_BREADY) begin b_hs++; b_fired = 1; end

                if (!M_AXI_RVALID && got_ar) begin
                    if (r_cnt >= r_delay) begin
                        M_AXI_RVALID = 1; M_AXI_RDATA = slv_mem[ar_addr_l[5:2]];
                        M_AXI_RRESP = rresp_cfg; r_cnt = 0; got_ar = 0;
                    end else r_cnt++;
                end
                if (M_AXI_RVALID && M_AXI_RREADY) begin r_hs++; r_fired = 1; end

                M_AXI_AWREADY = 0;
                if (M_AXI_AWVALID) begin
                    if (aw_cnt >= aw_delay) begin
                        M_AXI_AWREADY = 1; got_aw = 1; aw_addr_l = M_AXI_AWADDR; aw_cnt = 0; aw_hs++;
                    end else aw_cnt++;
                end
                M_AXI_WREADY = 0;
                if (M_AXI_WVALID) begin
                    if (w_cnt >= w_delay) begin
                        M_AXI_WREADY = 1; got_w = 1; w_data_l = M_AXI_WDATA;
                        w_strb_l = M_AXI_WSTRB; w_cnt = 0; w_hs++;
                    end else w_cnt++;
                end
                M_AXI_ARREADY = 0;
                if (M_AXI_ARVALID) begin
                    if (ar_cnt >= ar_delay) begin
                        M_AXI_ARREADY = 1; got_ar = 1; ar_addr_l = M_AXI_ARADDR; ar_cnt = 0; ar_hs++;
                    end else ar_cnt++;
                end
            end
        end
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, cr, cw, crsp, n;
        logic [31:0] d, a;
        logic [3:0]  s;
        logic [1:0]  rr;
        logic        wr;
        logic [34:0] q0;

        for (int k = 0; k < 16; k++) begin slv_mem[k] = '0; model_mem[k] = '0; end
        clear_mon();
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_awvalid", M_AXI_AWVALID, 0);
        chk("rst_wvalid", M_AXI_WVALID, 0);
        chk("rst_arvalid", M_AXI_ARVALID, 0);
        chk("rst_bready", M_AXI_BREADY, 0);
        chk("rst_rready", M_AXI_RREADY, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", {M_AXI_AWADDR, M_AXI_ARADDR}, 0);
        chk("rst_wdata_wstrb", {M_AXI_WDATA, M_AXI_WSTRB}, 0);
        chk("rst_rsp_fields", {rsp_rdata, rsp_resp}, 0);
        chk("rst_prot", {M_AXI_AWPROT, M_AXI_ARPROT}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_cmd_ready", cmd_ready, 1);

        // Zero-wait write: latency 1/2/3 cycles to AW+W, BREADY, rsp_valid.
        clear_mon(); set_delays(0, 0, 0, 0, 0); bresp_cfg = 2'b00;
        send_cmd(1'b1, 32'h0000_0000, 32'h0000_1234, 4'hF, c0);
        get_rsp("wr0", 0, 1'b1, 2'b00, 32'h0, crsp);
        model_write(32'h0, 32'h1234, 4'hF);
        chk("wr0_aw_cycle", aw_first, c0 + 1);
        chk("wr0_w_cycle", w_first, c0 + 1);
        chk("wr0_bready_cycle", bready_first, c0 + 2);
        chk("wr0_rsp_cycle", crsp, c0 + 3);
        chk("wr0_aw_len", awv_cycles, 1);
        chk("wr0_b_count", b_hs, 1);

        // AWREADY three cycles late, WREADY immediate.
        clear_mon(); set_delays(3, 0, 0, 0, 0);
        d = $urandom;
        send_cmd(1'b1, 32'h0000_0008, d, 4'b0011, c0);
        get_rsp("wr1", 0, 1'b1, 2'b00, 32'h0, crsp);
        model_write(32'h8, d, 4'b0011);
        chk("wr1_w_len", wv_cycles, 1);
        chk("wr1_aw_len", awv_cycles, 4);
        chk("wr1_awaddr_stable", awaddr_moved, 0);
        chk("wr1_bready_after_aw", bready_early, 0);
        chk("wr1_hs_counts", {aw_hs[7:0], w_hs[7:0], b_hs[7:0]}, 24'h010101);

        // Read with RVALID five cycles late.
        clear_mon(); set_delays(0, 0, 0, 0, 5); rresp_cfg = 2'b00;
        slv_mem[1] = 32'hDEAD_BEEF; model_mem[1] = 32'hDEAD_BEEF;
        send_cmd(1'b0, 32'h0000_0004, 32'h0, 4'h0, c0);
        get_rsp("rd0", 0, 1'b0, 2'b00, 32'hDEAD_BEEF, crsp);
        chk("rd0_ar_len", arv_cycles, 1);
        chk("rd0_rready_len", rrdy_cycles, 6);
        chk("rd0_r_count", r_hs, 1);
        chk("rd0_rsp_cycle", crsp, c0 + 8);

        // SLVERR write response with rsp_ready held low for 4 cycles.
        clear_mon(); set_delays(0, 0, 0, 0, 0); bresp_cfg = 2'b10;
        d = $urandom;
        send_cmd(1'b1, 32'h0000_000C, d, 4'hF, c0);
        get_rsp("wr_err", 4, 1'b1, 2'b10, 32'h0, crsp);
        model_write(32'hC, d, 4'hF);
        bresp_cfg = 2'b00;

        // Reset mid-WR_REQ aborts without a clock edge.
        clear_mon(); set_delays(20, 0, 0, 0, 0);
        send_cmd(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF, c0);
        @(posedge clk); #1;
        chk("abort_pre_awvalid", M_AXI_AWVALID, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_awvalid", M_AXI_AWVALID, 0);
        chk("abort_wvalid", M_AXI_WVALID, 0);
        chk("abort_busy", busy, 0);
        chk("abort_awaddr", M_AXI_AWADDR, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_delays(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        send_cmd(1'b0, 32'h0000_0004, 32'h0, 4'h0, c0);
        get_rsp("post_rst_rd", 0, 1'b0, 2'b00, model_mem[1], crsp);

        // Back-to-back write then read, cmd_valid held, rsp_ready tied high.
        clear_mon(); set_delays(0, 0, 0, 0, 0);
        rsp_ready = 1'b1;
        d = $urandom;
        cmd_write = 1'b1; cmd_addr = 32'h0000_0020; cmd_wdata = d; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        wait_accept(cw);
        cmd_write = 1'b0;
        wait_accept(cr);
        cmd_valid = 1'b0;
        model_write(32'h20, d, 4'hF);
        n = 0;
        while (rsp_q.size() < 2 && n < 200) begin @(posedge clk); #1; n++; end
        rsp_ready = 1'b0;
        chk("b2b_rsp_count", rsp_q.size(), 2);
        chk("b2b_read_after_wr_rsp", cr >= cw + 4, 1);
        chk("b2b_no_overlap", overlap, 0);
        chk("b2b_ready_only_idle", ready_while_busy, 0);
        if (rsp_q.size() == 2) begin
            q0 = rsp_q.pop_front();
            chk("b2b_wr_rsp", q0, {1'b1, 2'b00, 32'h0});
            q0 = rsp_q.pop_front();
            chk("b2b_rd_rsp", q0, {1'b0, 2'b00, model_mem[8]});
        end

        // Randomized commands against the word-memory model.
        for (int t = 0; t < 24; t++) begin
            clear_mon();
            set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            rr = 2'($urandom_range(0, 3));
            bresp_cfg = rr; rresp_cfg = rr;
            send_cmd(wr, a, d, s, c0);
            if (wr) begin
                get_rsp("rnd_wr", $urandom_range(0, 2), 1'b1, rr, 32'h0, crsp);
                model_write(a, d, s);
                chk("rnd_wr_hs", {aw_hs[7:0], w_hs[7:0], b_hs[7:0], ar_hs[7:0]}, 32'h01010100);
            end else begin
                get_rsp("rnd_rd", $urandom_range(0, 2), 1'b0, rr, model_mem[a[5:2]], crsp);
                chk("rnd_rd_hs", {ar_hs[7:0], r_hs[7:0], aw_hs[7:0]}, 24'h010100);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_master_cmd.md
Name: axil_master_cmd

Overview:
- AXI4-Lite initiator (master) that turns single-beat user commands into AXI4-Lite write or read transactions.
- Drives the register-mapped peripherals on the same bus, e.g. the seven-segment display slave, from on-chip logic such as the recognition-result path, without a processor.
- One transaction is outstanding at a time.
- The response (read data and RESP code) is returned on a held valid/ready interface.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, width of the AXI address bus and of cmd_addr.
- C_M_AXI_DATA_WIDTH, 32, width of the AXI data bus, cmd_wdata and rsp_rdata; only 32 is supported.

Ports:
- M_AXI_ACLK  in  1  sole clock; everything is rising-edge.
- M_AXI_ARESETN  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  user command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response valid, held until accepted.
- rsp_ready  in  1  response accept.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the transaction.
- rsp_was_write  out  1  tags the response as write (1) or read (0).
- busy  out  1  high in any state other than IDLE.
- M_AXI_AWADDR  out  ADDR_WIDTH
- M_AXI_AWPROT  out  3  constant 3'b000.
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  32
- M_AXI_WSTRB  out  4
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- M_AXI_ARADDR  out  ADDR_WIDTH
- M_AXI_ARPROT  out  3  constant 3'b000.
- M_AXI_ARVALID  out  1
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- Reset (async assert, sync release):
  - All VALID/READY outputs, rsp_valid and busy are 0.
  - Address, data, strobe, rsp_rdata and rsp_resp registers are 0.
  - State is IDLE.
  - Reset asserted mid-transaction aborts immediately: all outputs reach reset values with no clock edge required.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- All AXI outputs are registered; there are no combinational paths from AXI inputs to AXI outputs.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, capture addr, wdata and wstrb into the AXI output registers.
  - Write command: go to WR_REQ; AWVALID and WVALID both rise on the next cycle.
  - Read command: go to RD_REQ; ARVALID rises on the next cycle.
- WR_REQ:
  - AWVALID and WVALID are tracked independently.
  - Each drops the cycle after its own handshake (VALID & READY).
  - Whichever channel completes first stays low while the other is still waiting.
  - AWADDR, WDATA and WSTRB are stable while the corresponding VALID is high.
  - Once both handshakes are done (the same cycle or different cycles), go to WR_RESP.
- WR_RESP:
  - BREADY = 1.
  - On BVALID, latch BRESP into rsp_resp, set rsp_rdata = 0 and rsp_was_write = 1, then go to RSP.
  - BREADY drops the following cycle.
- RD_REQ:
  - ARVALID stays high until ARREADY, then drops; go to RD_DATA.
- RD_DATA:
  - RREADY = 1.
  - On RVALID, latch RDATA and RRESP, set rsp_was_write = 0, then go to RSP.
- RSP:
  - rsp_valid = 1, with rsp_* held stable.
  - On rsp_ready, go to IDLE; rsp_valid drops the next cycle.
  - The next command can be accepted one cycle after that.
- Never-withdraw rule: a VALID, once asserted, is never deasserted before its handshake. There is no timeout; the block waits indefinitely.
- Latency with a zero-wait-state slave and rsp_ready tied high:
  - Write: command accept at cycle 0, AW and W handshakes at cycle 1, B handshake at cycle 2, rsp_valid at cycle 3.
  - Read: accept at cycle 0, AR handshake at cycle 1, R handshake at cycle 2, rsp_valid at cycle 3.
- Non-OKAY responses (SLVERR, DECERR) are passed through in rsp_resp without retry.
- Commands presented while busy are ignored (cmd_ready = 0) and must be held by the user.

Test Plan:
- Zero-wait slave, write addr 0x0000_0000, data 0x0000_1234, wstrb 0xF -> AWVALID and WVALID high on cycle 1, BREADY high on cycle 2, rsp_valid on cycle 3 with rsp_resp = 2'b00, rsp_was_write = 1, rsp_rdata = 0.
- Slave with AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID is held 4 cycles with AWADDR stable, BREADY is asserted only after the AW handshake, and exactly one B is accepted.
- Read addr 0x4, slave returns RDATA 0xDEAD_BEEF with RVALID delayed 5 cycles -> ARVALID is high exactly 1 cycle, RREADY is held until RVALID, rsp_rdata = 0xDEAD_BEEF, rsp_was_write = 0.
- Slave returns BRESP = 2'b10 and rsp_ready is held low for 4 cycles -> rsp_valid and rsp_resp = 2'b10 are stable for all 4 cycles, cmd_ready = 0 throughout, and IDLE is re-entered after rsp_ready goes high.
- Assert M_AXI_ARESETN low while in WR_REQ with AWVALID high -> AWVALID, WVALID and busy go to 0 asynchronously; after release, a new read completes normally.
- Back-to-back write then read with cmd_valid held high -> the second command is accepted only in IDLE, with no overlap of AW, W and AR valids.
